// File: rtl/shift_reg_4_pkg.sv
// Shared width, reset value and word type for the 4-bit parallel-load shift register.
package shift_reg_4_pkg;

  localparam int SHIFT_REG_4_WIDTH = 4;

  typedef logic [SHIFT_REG_4_WIDTH-1:0] shift_reg_4_word_t;

  localparam shift_reg_4_word_t SHIFT_REG_4_RST_VAL = '0;

endpackage : shift_reg_4_pkg

// File: rtl/shift_reg_4_cell.sv
// One bit of the shift register: async-clear flop with a hold / load / shift-in next-state mux.
module shift_reg_4_cell #(
  parameter logic RST_BIT = 1'b0
) (
  input  logic clk,
  input  logic areset,
  input  logic load_i,
  input  logic load_bit_i,
  input  logic ena_i,
  input  logic shift_in_i,
  output logic q_o
);

  logic bit_d;
  logic bit_q;

  // Next-state select; load outranks shift, otherwise hold.
  always_comb begin
    bit_d = bit_q;
    if (load_i) begin
      bit_d = load_bit_i;
    end else if (ena_i) begin
      bit_d = shift_in_i;
    end else begin
      bit_d = bit_q;
    end
  end

  // State flop with asynchronous clear.
  always_ff @(posedge clk or posedge areset) begin
    if (areset) begin
      bit_q <= RST_BIT;
    end else begin
      bit_q <= bit_d;
    end
  end

  assign q_o = bit_q;

endmodule : shift_reg_4_cell

// File: rtl/shift_reg_4.sv
// 4-bit parallel-load, logical right-shift register with asynchronous clear.
// Define SHIFT_REG_4_ASSERT_EN to compile in simulation-only SVA checks.
module shift_reg_4
  import shift_reg_4_pkg::*;
#(
  parameter int WIDTH = SHIFT_REG_4_WIDTH
) (
  input  logic [WIDTH-1:0] in,
  input  logic             areset,
  input  logic             load,
  input  logic             clk,
  input  logic             ena,
  output logic [WIDTH-1:0] Q
);

  wire  [WIDTH-1:0] q_s;
  logic [WIDTH-1:0] shift_src_s;

  // Each cell takes its upper neighbour; zeros enter at the MSB.
  assign shift_src_s = {1'b0, q_s[WIDTH-1:1]};

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    shift_reg_4_cell #(
      .RST_BIT (SHIFT_REG_4_RST_VAL[i])
    ) u_cell (
      .clk        (clk),
      .areset     (areset),
      .load_i     (load),
      .load_bit_i (in[i]),
      .ena_i      (ena),
      .shift_in_i (shift_src_s[i]),
      .q_o        (q_s[i])
    );
  end

  assign Q = q_s;

`ifdef SHIFT_REG_4_ASSERT_EN
  a_reset_clear : assert property (@(posedge clk) areset |-> (Q == '0));

  a_load : assert property (@(posedge clk) disable iff (areset)
    ($past(load) && !$past(areset)) |-> (Q == $past(in)));

  a_shift : assert property (@(posedge clk) disable iff (areset)
    ($past(ena) && !$past(load) && !$past(areset)) |-> (Q == ($past(Q) >> 1)));

  a_shift_msb : assert property (@(posedge clk) disable iff (areset)
    ($past(ena) && !$past(load) && !$past(areset)) |-> (Q[WIDTH-1] == 1'b0));
`else
`endif

endmodule : shift_reg_4

// File: tb/tb_shift_reg_4.sv
// Directed self-checking bench for shift_reg_4; inputs change on falling edges.
module tb_shift_reg_4;

  logic       clk = 1'b0;
  logic       areset = 1'b0;
  logic       load = 1'b0;
  logic       ena = 1'b0;
  logic [3:0] in_s = 4'b0000;
  logic [3:0] q_s;
  int         checks = 0;
  int         failures = 0;

  always #5 clk = ~clk;

  shift_reg_4 dut (
    .in     (in_s),
    .areset (areset),
    .load   (load),
    .clk    (clk),
    .ena    (ena),
    .Q      (q_s)
  );

  task automatic step(input logic l, input logic e, input logic [3:0] d);
    @(negedge clk);
    load = l;
    ena  = e;
    in_s = d;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    @(negedge clk);
    areset = 1'b1;
    #2;
    checks++;
    if (q_s !== 4'b0000) begin
      failures++;
      $display("FAIL reset_async: Q=%b expected %b", q_s, 4'b0000);
    end
    @(negedge clk);
    areset = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (q_s !== 4'b0000) begin
      failures++;
      $display("FAIL reset_after: Q=%b expected %b", q_s, 4'b0000);
    end
  endtask

  task automatic test_load();
    logic [3:0] exp_v;
    step(1'b1, 1'b0, 4'b1010);
    exp_v = 4'b1010;
    checks++;
    if (q_s !== exp_v) begin
      failures++;
      $display("FAIL load: Q=%b expected %b", q_s, exp_v);
    end
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b0, 4'b0101);
      checks++;
      if (q_s !== exp_v) begin
        failures++;
        $display("FAIL load_hold[%0d]: Q=%b expected %b", i, q_s, exp_v);
      end
    end
  endtask

  task automatic test_shift();
    logic [3:0] exp_seq [3];
    logic       ena_seq [3];
    exp_seq = '{4'b0101, 4'b0010, 4'b0010};
    ena_seq = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      step(1'b0, ena_seq[i], 4'b1111);
      checks++;
      if (q_s !== exp_seq[i]) begin
        failures++;
        $display("FAIL shift[%0d]: Q=%b expected %b", i, q_s, exp_seq[i]);
      end
    end
  endtask

  task automatic test_load_priority();
    step(1'b1, 1'b1, 4'b1100);
    checks++;
    if (q_s !== 4'b1100) begin
      failures++;
      $display("FAIL load_priority: Q=%b expected %b", q_s, 4'b1100);
    end
  endtask

  task automatic test_continued_shift();
    logic [3:0] exp_seq [2];
    exp_seq = '{4'b0110, 4'b0011};
    for (int i = 0; i < 2; i++) begin
      step(1'b0, 1'b1, 4'b0000);
      checks++;
      if (q_s !== exp_seq[i]) begin
        failures++;
        $display("FAIL cont_shift[%0d]: Q=%b expected %b", i, q_s, exp_seq[i]);
      end
    end
  endtask

  task automatic test_drain();
    logic [3:0] exp_seq [5];
    exp_seq = '{4'b0111, 4'b0011, 4'b0001, 4'b0000, 4'b0000};
    step(1'b1, 1'b0, 4'b1111);
    checks++;
    if (q_s !== 4'b1111) begin
      failures++;
      $display("FAIL drain_load: Q=%b expected %b", q_s, 4'b1111);
    end
    for (int i = 0; i < 5; i++) begin
      step(1'b0, 1'b1, 4'b1111);
      checks++;
      if (q_s !== exp_seq[i]) begin
        failures++;
        $display("FAIL drain[%0d]: Q=%b expected %b", i, q_s, exp_seq[i]);
      end
    end
  endtask

  task automatic test_reset_mid_op();
    step(1'b1, 1'b0, 4'b1011);
    checks++;
    if (q_s !== 4'b1011) begin
      failures++;
      $display("FAIL mid_load: Q=%b expected %b", q_s, 4'b1011);
    end
    @(negedge clk);
    load = 1'b0;
    ena  = 1'b1;
    #2;
    areset = 1'b1;
    #1;
    checks++;
    if (q_s !== 4'b0000) begin
      failures++;
      $display("FAIL reset_mid_shift: Q=%b expected %b", q_s, 4'b0000);
    end
    @(negedge clk);
    load = 1'b1;
    in_s = 4'b1001;
    @(posedge clk);
    #1;
    checks++;
    if (q_s !== 4'b0000) begin
      failures++;
      $display("FAIL reset_held_load: Q=%b expected %b", q_s, 4'b0000);
    end
  endtask

  task automatic test_reset_release();
    @(negedge clk);
    areset = 1'b0;
    load   = 1'b1;
    ena    = 1'b0;
    in_s   = 4'b0110;
    @(posedge clk);
    #1;
    checks++;
    if (q_s !== 4'b0110) begin
      failures++;
      $display("FAIL release_load: Q=%b expected %b", q_s, 4'b0110);
    end
    step(1'b0, 1'b1, 4'b0000);
    checks++;
    if (q_s !== 4'b0011) begin
      failures++;
      $display("FAIL release_shift: Q=%b expected %b", q_s, 4'b0011);
    end
  endtask

  initial begin
    test_reset();
    test_load();
    test_shift();
    test_load_priority();
    test_continued_shift();
    test_drain();
    test_reset_mid_op();
    test_reset_release();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_shift_reg_4
